// File: rtl/axi_lite_regfile_pkg.sv
// ============================================================================
// Module : axi_lite_regfile_pkg
// Brief  : FSM state types, AXI response codes and sizing helper for the
//          AXI-Lite register file responder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package axi_lite_regfile_pkg;

  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } w_state_e;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } r_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Index width never drops below one bit so a single-register bank still
  // has a legal index vector.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/axi_lite_regfile_decode.sv
// ============================================================================
// Module : axi_lite_regfile_decode
// Brief  : Maps a byte address to {register index, in-range, read-only}.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module axi_lite_regfile_decode
  import axi_lite_regfile_pkg::*;
#(
  parameter int unsigned          NUM_REGS       = 4,
  parameter int unsigned          AXI_ADDR_WIDTH = 32,
  parameter int unsigned          AXI_STRB_WIDTH = 4,
  parameter logic [NUM_REGS-1:0]  RO_MASK        = '0,
  parameter int unsigned          IDX_W          = idx_width(NUM_REGS)
) (
  input  logic [AXI_ADDR_WIDTH-1:0] addr_i,
  output logic [IDX_W-1:0]          idx_o,
  output logic                      in_range_o,
  output logic                      is_ro_o
);

  localparam int unsigned               LSB   = $clog2(AXI_STRB_WIDTH);
  localparam logic [AXI_ADDR_WIDTH-1:0] LIMIT = AXI_ADDR_WIDTH'(NUM_REGS * AXI_STRB_WIDTH);

  assign idx_o      = addr_i[LSB +: IDX_W];
  assign in_range_o = (addr_i < LIMIT);

  // Loop compare keeps the mask lookup safe when NUM_REGS is not a power of two.
  always_comb begin
    is_ro_o = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx_o == IDX_W'(i)) is_ro_o = RO_MASK[i];
    end
    is_ro_o = is_ro_o & in_range_o;
  end

endmodule

`default_nettype wire

// File: rtl/axi_lite_regfile_slv.sv
// ============================================================================
// Module : axi_lite_regfile_slv
// Brief  : AXI-Lite register file responder with RO hardware-sourced slots.
//          Define AXI_LITE_REGFILE_SLV_DECERR_EN for DECERR on out-of-range.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module axi_lite_regfile_slv
  import axi_lite_regfile_pkg::*;
#(
  parameter int unsigned                              NUM_REGS       = 4,
  parameter int unsigned                              AXI_ADDR_WIDTH = 32,
  parameter int unsigned                              AXI_DATA_WIDTH = 32,
  parameter int unsigned                              AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
  parameter logic [NUM_REGS-1:0]                      RO_MASK        = '0,
  parameter logic [NUM_REGS*AXI_DATA_WIDTH-1:0]       RESET_VAL      = '0
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [AXI_ADDR_WIDTH-1:0]          aw_addr_i,
  input  logic [2:0]                         aw_prot_i,
  input  logic                               aw_valid_i,
  output logic                               aw_ready_o,
  input  logic [AXI_DATA_WIDTH-1:0]          w_data_i,
  input  logic [AXI_STRB_WIDTH-1:0]          w_strb_i,
  input  logic                               w_valid_i,
  output logic                               w_ready_o,
  output logic [1:0]                         b_resp_o,
  output logic                               b_valid_o,
  input  logic                               b_ready_i,
  input  logic [AXI_ADDR_WIDTH-1:0]          ar_addr_i,
  input  logic [2:0]                         ar_prot_i,
  input  logic                               ar_valid_i,
  output logic                               ar_ready_o,
  output logic [AXI_DATA_WIDTH-1:0]          r_data_o,
  output logic [1:0]                         r_resp_o,
  output logic                               r_valid_o,
  input  logic                               r_ready_i,
  output logic [NUM_REGS*AXI_DATA_WIDTH-1:0] reg_q_o,
  input  logic [NUM_REGS*AXI_DATA_WIDTH-1:0] reg_d_i,
  output logic [NUM_REGS-1:0]                reg_wr_o
);

  localparam int unsigned DW    = AXI_DATA_WIDTH;
  localparam int unsigned IDX_W = idx_width(NUM_REGS);

`ifdef AXI_LITE_REGFILE_SLV_DECERR_EN
  localparam logic [1:0] OOR_RESP = RESP_DECERR;
`else
  localparam logic [1:0] OOR_RESP = RESP_OKAY;
`endif

  w_state_e             w_state_q;
  r_state_e             r_state_q;
  logic [1:0]           b_resp_q, b_resp_d;
  logic [1:0]           r_resp_q, r_resp_d;
  logic [DW-1:0]        r_data_q, r_data_d, r_sel;
  logic [NUM_REGS-1:0]  reg_wr_q, wr_en;
  logic [DW-1:0]        reg_val [NUM_REGS];

  logic [IDX_W-1:0]     aw_idx, ar_idx;
  logic                 aw_in_range, aw_is_ro, ar_in_range, ar_is_ro;
  logic                 aw_hs, ar_hs;

  logic unused_w;
  assign unused_w = ^{aw_prot_i, ar_prot_i, reg_d_i, w_data_i, w_strb_i, ar_is_ro};

  axi_lite_regfile_decode #(
    .NUM_REGS       (NUM_REGS),
    .AXI_ADDR_WIDTH (AXI_ADDR_WIDTH),
    .AXI_STRB_WIDTH (AXI_STRB_WIDTH),
    .RO_MASK        (RO_MASK),
    .IDX_W          (IDX_W)
  ) u_aw_dec (
    .addr_i     (aw_addr_i),
    .idx_o      (aw_idx),
    .in_range_o (aw_in_range),
    .is_ro_o    (aw_is_ro)
  );

  axi_lite_regfile_decode #(
    .NUM_REGS       (NUM_REGS),
    .AXI_ADDR_WIDTH (AXI_ADDR_WIDTH),
    .AXI_STRB_WIDTH (AXI_STRB_WIDTH),
    .RO_MASK        (RO_MASK),
    .IDX_W          (IDX_W)
  ) u_ar_dec (
    .addr_i     (ar_addr_i),
    .idx_o      (ar_idx),
    .in_range_o (ar_in_range),
    .is_ro_o    (ar_is_ro)
  );

  // ---------------------------------------------------------------- write ---
  // AW and W are accepted only together, so neither channel can get ahead.
  assign aw_hs      = (w_state_q == W_IDLE) & aw_valid_i & w_valid_i & ~rst_i;
  assign aw_ready_o = aw_hs;
  assign w_ready_o  = aw_hs;
  assign b_valid_o  = (w_state_q == W_RESP);
  assign b_resp_o   = b_resp_q;
  assign reg_wr_o   = reg_wr_q;

  always_comb begin
    wr_en = '0;
    if (aw_hs && aw_in_range && !aw_is_ro) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (aw_idx == IDX_W'(i)) wr_en[i] = 1'b1;
      end
    end
  end

  always_comb begin
    b_resp_d = RESP_OKAY;
    if (!aw_in_range)  b_resp_d = OOR_RESP;
    else if (aw_is_ro) b_resp_d = RESP_SLVERR;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_state_q <= W_IDLE;
      b_resp_q  <= RESP_OKAY;
      reg_wr_q  <= '0;
    end else begin
      reg_wr_q <= wr_en;
      case (w_state_q)
        W_IDLE: begin
          if (aw_hs) begin
            b_resp_q  <= b_resp_d;
            w_state_q <= W_RESP;
          end
        end
        W_RESP: begin
          if (b_ready_i) w_state_q <= W_IDLE;
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------ registers ---
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    if (RO_MASK[g]) begin : g_ro
      assign reg_val[g] = reg_d_i[g*DW +: DW];
    end else begin : g_rw
      logic [DW-1:0] data_q, data_d;

      always_comb begin
        data_d = data_q;
        for (int b = 0; b < AXI_STRB_WIDTH; b++) begin
          if (wr_en[g] && w_strb_i[b]) data_d[b*8 +: 8] = w_data_i[b*8 +: 8];
        end
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) data_q <= RESET_VAL[g*DW +: DW];
        else       data_q <= data_d;
      end

      assign reg_val[g] = data_q;
    end
    assign reg_q_o[g*DW +: DW] = reg_val[g];
  end

  // ----------------------------------------------------------------- read ---
  assign ar_hs      = (r_state_q == R_IDLE) & ar_valid_i & ~rst_i;
  assign ar_ready_o = (r_state_q == R_IDLE) & ~rst_i;
  assign r_valid_o  = (r_state_q == R_RESP);
  assign r_data_o   = r_data_q;
  assign r_resp_o   = r_resp_q;

  always_comb begin
    r_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == IDX_W'(i)) r_sel = reg_val[i];
    end
    r_data_d = ar_in_range ? r_sel : '0;
    r_resp_d = ar_in_range ? RESP_OKAY : OOR_RESP;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state_q <= R_IDLE;
      r_data_q  <= '0;
      r_resp_q  <= RESP_OKAY;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (ar_hs) begin
            r_data_q  <= r_data_d;
            r_resp_q  <= r_resp_d;
            r_state_q <= R_RESP;
          end
        end
        R_RESP: begin
          if (r_ready_i) r_state_q <= R_IDLE;
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
